// File: rtl/switch_port_endpoint.sv
// Host-side endpoint for one switch port. TX queues host requests and paces them
// with an optional inter-packet gap. RX checks the routing and keeps statistics.
//
//   state  | meaning
//   IDLE   | nothing on the wire, head of queue may be fetched
//   SEND   | tx_valid high for this cycle
//   GAP    | forced idle cycles before the next fetch
module switch_port_endpoint #(
  parameter logic [3:0] PORT_ID    = 4'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MIN_GAP    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_target,
  input  logic [7:0]  req_data,
  output logic        tx_valid,
  output logic [3:0]  tx_source,
  output logic [3:0]  tx_target,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  input  logic [3:0]  rx_source,
  input  logic [3:0]  rx_target,
  input  logic [7:0]  rx_data,
  output logic        rx_pkt_valid,
  output logic [3:0]  rx_pkt_source,
  output logic [7:0]  rx_pkt_data,
  output logic [15:0] tx_count,
  output logic [7:0]  tx_drop_count,
  output logic [15:0] rx_count,
  output logic [7:0]  rx_misroute_count,
  output logic        idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [11:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic        fifo_empty, fifo_full;
  logic        push, pop, load, drop, can_fetch;
  logic [11:0] head;
  logic        head_routable;
  logic [GW-1:0] gap_q, gap_d;
  logic        rx_hit, rx_miss;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  // Targets 4..15 do not exist on a 4-port switch; sending to ourselves is also refused.
  assign head_routable = (head[11:10] == 2'b00) && (head[11:8] != PORT_ID);
  assign wr_ptr_d   = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_d   = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {req_target, req_data};
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    can_fetch = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    case (state_q)
      S_IDLE: can_fetch = 1'b1;
      S_SEND: begin
        if (MIN_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GW'(MIN_GAP);
        end else begin
          can_fetch = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) can_fetch = 1'b1;
        else                 gap_d = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // The last gap cycle behaves exactly like IDLE, so a fetch can happen on it.
    if (can_fetch) begin
      state_d = S_IDLE;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_routable) begin
          load    = 1'b1;
          state_d = S_SEND;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gap_q         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_valid      <= 1'b0;
      tx_source     <= 4'd0;
      tx_target     <= 4'd0;
      tx_data       <= 8'd0;
      tx_count      <= 16'd0;
      tx_drop_count <= 8'd0;
      idle          <= 1'b1;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      tx_valid <= load;
      if (load) begin
        tx_source <= PORT_ID;
        tx_target <= head[11:8];
        tx_data   <= head[7:0];
        if (tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
      end
      if (drop && tx_drop_count != 8'hFF) tx_drop_count <= tx_drop_count + 8'd1;
      idle <= (wr_ptr_d == rd_ptr_d) && (state_d == S_IDLE);
    end
  end

  assign rx_hit  = rx_valid && (rx_target == PORT_ID);
  assign rx_miss = rx_valid && (rx_target != PORT_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pkt_valid      <= 1'b0;
      rx_pkt_source     <= 4'd0;
      rx_pkt_data       <= 8'd0;
      rx_count          <= 16'd0;
      rx_misroute_count <= 8'd0;
    end else begin
      rx_pkt_valid <= rx_hit;
      if (rx_hit) begin
        rx_pkt_source <= rx_source;
        rx_pkt_data   <= rx_data;
        if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
      end
      if (rx_miss && rx_misroute_count != 8'hFF)
        rx_misroute_count <= rx_misroute_count + 8'd1;
    end
  end

endmodule
